// File: rtl/mjpg_pkg.sv
// Shared definitions for the MJPG byte-stream parser.
//   - JPEG marker codes the parser reacts to
//   - parser state encoding
//   - zero-based SOF0 body offsets of the height/width fields
package mjpg_pkg;

   localparam logic [7:0] M_FF   = 8'hFF;
   localparam logic [7:0] M_SOI  = 8'hD8;
   localparam logic [7:0] M_EOI  = 8'hD9;
   localparam logic [7:0] M_SOF0 = 8'hC0;
   localparam logic [7:0] M_SOS  = 8'hDA;
   localparam logic [7:0] M_RST0 = 8'hD0;

   // Body byte 0 of SOF0 is the sample precision; the geometry follows it.
   localparam logic [2:0] SOF_H_HI = 3'd1;
   localparam logic [2:0] SOF_H_LO = 3'd2;
   localparam logic [2:0] SOF_W_HI = 3'd3;
   localparam logic [2:0] SOF_W_LO = 3'd4;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_MARK,
      ST_LEN_HI,
      ST_LEN_LO,
      ST_SEG,
      ST_SEG_END,
      ST_ECS,
      ST_ECS_FF
   } parse_state_t;

   // RST0..RST7 share the upper five bits with RST0.
   function automatic logic is_rst_marker(input logic [7:0] code);
      return code[7:3] == M_RST0[7:3];
   endfunction

endpackage

// File: rtl/mjpg_byte_fifo.sv
// Synchronous FIFO, DW bits x 2^AW entries, with a registered head.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_push/i_din  write request and data (ignored when full unless popping)
//   i_pop         read request (ignored when empty)
//   o_full        all entries occupied
//   o_empty       no entries; o_head then holds the last head value
//   o_head        current head entry
module mjpg_byte_fifo #(
   parameter int AW = 4,
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_din,
   input  logic          i_pop,
   output logic          o_full,
   output logic          o_empty,
   output logic [DW-1:0] o_head
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic [DW-1:0] r_head;
   logic          w_pop;
   logic          w_wr;

   assign o_empty = (r_cnt == '0);
   assign o_full  = r_cnt[AW];
   assign o_head  = r_head;
   assign w_pop   = i_pop && !o_empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign w_wr    = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_cnt  <= '0;
         r_head <= '0;
      end else begin
         if (w_wr)  r_wr <= r_wr + 1'b1;
         if (w_pop) r_rd <= r_rd + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
         // Head register tracks mem[r_rd] while non-empty, holds when empty.
         if (w_pop) begin
            if (r_cnt > (AW+1)'(1)) r_head <= r_mem[r_rd + 1'b1];
            else if (w_wr)          r_head <= i_din;
         end else if (o_empty && w_wr) begin
            r_head <= i_din;
         end
      end
   end

endmodule

// File: rtl/mjpg_stream_parser.sv
// JPEG byte-stream parser: follows markers, skips header segments, captures
// SOF0 geometry and queues destuffed entropy bytes plus an end-of-image token.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   jvalid, jpeg        input byte stream, no backpressure
//   ovalid/oready       output FIFO handshake
//   odata, oeoi         head byte / end-of-image token flag
//   frame_start         one-cycle pulse on entry to entropy-coded data
//   width, height       SOF0 geometry of the latest frame
//   err, overflow       sticky status, cleared by SOI
//
// state      | meaning
// HUNT       | waiting for FF
// MARK       | next byte is a marker code (FF is fill)
// LEN_HI     | segment length, high byte
// LEN_LO     | segment length, low byte
// SEG        | skipping segment body, counting down
// SEG_END    | transient decision point, resolved combinationally, never held
// ECS        | entropy-coded data
// ECS_FF     | FF seen inside entropy-coded data
module mjpg_stream_parser
   import mjpg_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jvalid,
   input  logic [7:0]  jpeg,
   output logic        ovalid,
   input  logic        oready,
   output logic [7:0]  odata,
   output logic        oeoi,
   output logic        frame_start,
   output logic [15:0] width,
   output logic [15:0] height,
   output logic        err,
   output logic        overflow
);

   parse_state_t r_state, w_state_nxt;
   logic [7:0]   r_code;
   logic [7:0]   r_len_hi;
   logic [15:0]  r_cnt;
   logic [2:0]   r_idx;
   logic [15:0]  r_width, r_height;
   logic         r_err, r_ovf, r_fs;

   logic [15:0]  w_len;
   logic         w_push, w_set_err, w_clr, w_fs, w_seg_end;
   logic [8:0]   w_din;
   logic         w_full, w_empty, w_drop;
   logic [8:0]   w_head;

   assign w_len = {r_len_hi, jpeg};

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_din       = '0;
      w_set_err   = 1'b0;
      w_clr       = 1'b0;
      w_fs        = 1'b0;
      w_seg_end   = 1'b0;
      if (jvalid) begin
         case (r_state)
            ST_HUNT:   if (jpeg == M_FF) w_state_nxt = ST_MARK;
            ST_MARK: begin
               if (jpeg == M_FF) begin
                  w_state_nxt = ST_MARK;
               end else if (jpeg == M_SOI) begin
                  w_clr       = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else if (jpeg == M_EOI) begin
                  w_state_nxt = ST_HUNT;
               end else if (jpeg == 8'h00 || is_rst_marker(jpeg)) begin
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else begin
                  w_state_nxt = ST_LEN_HI;
               end
            end
            ST_LEN_HI: w_state_nxt = ST_LEN_LO;
            ST_LEN_LO: begin
               if (w_len < 16'd2) begin
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_HUNT;
               end else if (w_len == 16'd2) begin
                  w_seg_end = 1'b1;
               end else begin
                  w_state_nxt = ST_SEG;
               end
            end
            // Terminal count: this byte takes the counter from 1 to 0.
            ST_SEG:    if (r_cnt == 16'd1) w_seg_end = 1'b1;
            ST_ECS: begin
               if (jpeg == M_FF) begin
                  w_state_nxt = ST_ECS_FF;
               end else begin
                  w_push = 1'b1;
                  w_din  = {1'b0, jpeg};
               end
            end
            ST_ECS_FF: begin
               if (jpeg == 8'h00) begin
                  w_push      = 1'b1;
                  w_din       = {1'b0, M_FF};
                  w_state_nxt = ST_ECS;
               end else if (is_rst_marker(jpeg)) begin
                  w_state_nxt = ST_ECS;
               end else if (jpeg == M_FF) begin
                  w_state_nxt = ST_ECS_FF;
               end else if (jpeg == M_EOI) begin
                  w_push      = 1'b1;
                  w_din       = 9'h100;
                  w_state_nxt = ST_HUNT;
               end else begin
                  w_set_err   = 1'b1;
                  w_state_nxt = ST_HUNT;
               end
            end
            default:   w_state_nxt = ST_HUNT;
         endcase
         if (w_seg_end) begin
            if (r_code == M_SOS) begin
               w_state_nxt = ST_ECS;
               w_fs        = 1'b1;
            end else begin
               w_state_nxt = ST_HUNT;
            end
         end
      end
   end

   // When full the FIFO is non-empty, so a pop happens exactly when oready.
   assign w_drop = w_push && w_full && !oready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_HUNT;
         r_code   <= '0;
         r_len_hi <= '0;
         r_cnt    <= '0;
         r_idx    <= '0;
         r_width  <= '0;
         r_height <= '0;
         r_err    <= 1'b0;
         r_ovf    <= 1'b0;
         r_fs     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fs    <= w_fs;
         if (w_clr)          r_err <= 1'b0;
         else if (w_set_err) r_err <= 1'b1;
         if (w_clr)          r_ovf <= 1'b0;
         else if (w_drop)    r_ovf <= 1'b1;
         if (jvalid) begin
            case (r_state)
               ST_MARK:   r_code   <= jpeg;
               ST_LEN_HI: r_len_hi <= jpeg;
               ST_LEN_LO: begin
                  r_cnt <= w_len - 16'd2;
                  r_idx <= '0;
               end
               ST_SEG: begin
                  r_cnt <= r_cnt - 16'd1;
                  if (r_idx != 3'd7) r_idx <= r_idx + 3'd1;
                  if (r_code == M_SOF0) begin
                     case (r_idx)
                        SOF_H_HI: r_height[15:8] <= jpeg;
                        SOF_H_LO: r_height[7:0]  <= jpeg;
                        SOF_W_HI: r_width[15:8]  <= jpeg;
                        SOF_W_LO: r_width[7:0]   <= jpeg;
                        default:  ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
      end
   end

   mjpg_byte_fifo #(.AW(FIFO_AW), .DW(9)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (oready),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign ovalid      = !w_empty;
   assign odata       = w_head[7:0];
   assign oeoi        = w_head[8];
   assign frame_start = r_fs;
   assign width       = r_width;
   assign height      = r_height;
   assign err         = r_err;
   assign overflow    = r_ovf;

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Bench for mjpg_stream_parser. Streams are built from frame-level pieces;
// the expected output queue is the unstuffed data the generator chose.
module tb_mjpg_stream_parser;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        jvalid = 1'b0;
   logic [7:0]  jpeg = 8'h00;
   logic        oready = 1'b1;
   logic        ovalid, oeoi, frame_start, err, overflow;
   logic [7:0]  odata;
   logic [15:0] width, height;

   always #5 clk = ~clk;

   mjpg_stream_parser #(.FIFO_AW(4)) dut (
      .clk(clk), .rst(rst), .jvalid(jvalid), .jpeg(jpeg),
      .ovalid(ovalid), .oready(oready), .odata(odata), .oeoi(oeoi),
      .frame_start(frame_start), .width(width), .height(height),
      .err(err), .overflow(overflow)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         fs_cnt = 0;
   int         fs_exp = 0;
   logic [8:0] got[$];
   logic [8:0] exp_q[$];
   logic [7:0] stream[$];
   bit         gap_mode = 0, rnd_ready = 0, rnd_gap = 0;

   logic [7:0] MF [42] = '{
      8'hFF, 8'hD8,
      8'hFF, 8'hC0, 8'h00, 8'h11, 8'h08, 8'h00, 8'hF0, 8'h01, 8'h40, 8'h03,
      8'h01, 8'h11, 8'h00, 8'h02, 8'h11, 8'h00, 8'h03, 8'h11, 8'h00,
      8'hFF, 8'hDA, 8'h00, 8'h0C,
      8'h03, 8'h01, 8'h00, 8'h02, 8'h11, 8'h03, 8'h11, 8'h00, 8'h3F, 8'h00,
      8'h12, 8'h34, 8'hFF, 8'h00, 8'h56,
      8'hFF, 8'hD9};

   always @(negedge clk) begin
      if (rst) begin
         if (ovalid && oready) got.push_back({oeoi, odata});
         if (frame_start) fs_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) oready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_byte(input logic [7:0] b);
      jvalid = 1'b1;
      jpeg   = b;
      tick();
      jvalid = 1'b0;
      jpeg   = 8'($urandom);
      if (gap_mode) tick();
      if (rnd_gap && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
   endtask

   task automatic send_stream();
      while (stream.size() > 0) send_byte(stream.pop_front());
   endtask

   task automatic put(input logic [7:0] b);
      stream.push_back(b);
   endtask

   task automatic mk_min();
      for (int i = 0; i < 42; i++) put(MF[i]);
      exp_q.push_back(9'h012);
      exp_q.push_back(9'h034);
      exp_q.push_back(9'h0FF);
      exp_q.push_back(9'h056);
      exp_q.push_back(9'h100);
      fs_exp++;
   endtask

   task automatic mk_seg(input logic [7:0] code, input int n);
      logic [15:0] l;
      l = 16'(n + 2);
      repeat ($urandom_range(0, 1)) put(8'hFF);
      put(8'hFF); put(code); put(l[15:8]); put(l[7:0]);
      repeat (n) put(8'($urandom));
   endtask

   task automatic mk_sof(input logic [15:0] w, input logic [15:0] h, input int npad);
      logic [15:0] l;
      l = 16'(8 + npad);
      put(8'hFF); put(8'hC0); put(l[15:8]); put(l[7:0]);
      put(8'h08); put(h[15:8]); put(h[7:0]); put(w[15:8]); put(w[7:0]); put(8'h03);
      repeat (npad) put(8'($urandom));
   endtask

   task automatic mk_ecs(input int n);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         put(d);
         if (d == 8'hFF) put(8'h00);
         exp_q.push_back({1'b0, d});
         if ($urandom_range(0, 4) == 0) begin
            repeat ($urandom_range(0, 2)) put(8'hFF);
            put(8'hFF);
            put(8'hD0 + 8'($urandom_range(0, 7)));
         end
      end
   endtask

   task automatic mk_eoi();
      repeat ($urandom_range(0, 1)) put(8'hFF);
      put(8'hFF); put(8'hD9);
      exp_q.push_back(9'h100);
   endtask

   task automatic drain_check(input string tag);
      int k;
      for (int i = 0; i < 300 && got.size() < exp_q.size(); i++) tick();
      repeat (4) tick();
      chk({tag, " count"}, got.size(), exp_q.size());
      k = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < k; i++) chk($sformatf("%s item%0d", tag, i), got[i], exp_q[i]);
      chk({tag, " frame_start count"}, fs_cnt, fs_exp);
      chk({tag, " ovalid idle"}, ovalid, 1'b0);
      got.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [15:0] w, h;

      // reset values
      tick(); tick();
      chk("rst ovalid", ovalid, 1'b0);
      chk("rst odata", odata, 8'h00);
      chk("rst oeoi", oeoi, 1'b0);
      chk("rst frame_start", frame_start, 1'b0);
      chk("rst width", width, 16'h0);
      chk("rst height", height, 16'h0);
      chk("rst err", err, 1'b0);
      chk("rst overflow", overflow, 1'b0);
      rst = 1'b1;
      tick();

      // minimal frame
      mk_min();
      send_stream();
      drain_check("min");
      chk("min width", width, 16'd320);
      chk("min height", height, 16'd240);
      chk("min err", err, 1'b0);

      // same frame with jvalid gaps and leading padding
      gap_mode = 1;
      put(8'h7F);
      mk_min();
      send_stream();
      gap_mode = 0;
      drain_check("gap");
      chk("gap width", width, 16'd320);
      chk("gap height", height, 16'd240);
      chk("gap err", err, 1'b0);

      // restart markers, fill and stuffing inside ECS; SOS with L=2
      foreach (MF[i]) if (i < 2) put(MF[i]);
      put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
      put(8'hAB); put(8'hFF); put(8'hD3); put(8'hCD); put(8'hFF); put(8'hFF);
      put(8'hFF); put(8'h00); put(8'hEF); put(8'hFF); put(8'hD9);
      exp_q.push_back(9'h0AB); exp_q.push_back(9'h0CD);
      exp_q.push_back(9'h0FF); exp_q.push_back(9'h0EF);
      exp_q.push_back(9'h100);
      fs_exp++;
      send_stream();
      drain_check("ecs");
      chk("ecs err", err, 1'b0);

      // overflow with oready held low
      oready = 1'b0;
      put(8'hFF); put(8'hD8); put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
      fs_exp++;
      for (int i = 0; i < 16; i++) begin
         put(8'h10 + 8'(i));
         exp_q.push_back({1'b0, 8'h10 + 8'(i)});
      end
      send_stream();
      chk("ovf ovalid full", ovalid, 1'b1);
      chk("ovf before 17th", overflow, 1'b0);
      send_byte(8'h60);
      chk("ovf at 17th", overflow, 1'b1);
      send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
      chk("ovf err", err, 1'b0);
      chk("ovf head", {oeoi, odata}, 9'h010);
      oready = 1'b1;
      put(8'hFF); put(8'hD9);
      exp_q.push_back(9'h100);
      send_stream();
      drain_check("ovf");
      chk("ovf sticky", overflow, 1'b1);
      put(8'hFF); put(8'hD8);
      send_stream();
      chk("ovf cleared", overflow, 1'b0);
      chk("ovf err after soi", err, 1'b0);

      // invalid marker inside ECS
      put(8'hFF); put(8'hD8); put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
      put(8'h11); put(8'hFF); put(8'h45); put(8'h22); put(8'h33);
      exp_q.push_back(9'h011);
      fs_exp++;
      send_stream();
      chk("bad marker err", err, 1'b1);
      mk_sof(16'h0123, 16'h0456, 2);
      put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
      put(8'h44); put(8'hFF); put(8'hD9);
      exp_q.push_back(9'h044); exp_q.push_back(9'h100);
      fs_exp++;
      send_stream();
      drain_check("bad marker");
      chk("next frame err sticky", err, 1'b1);
      chk("next frame width", width, 16'h0123);
      chk("next frame height", height, 16'h0456);
      put(8'hFF); put(8'hD8);
      send_stream();
      chk("err cleared by soi", err, 1'b0);

      // segment length below 2, and RSTn outside ECS
      put(8'hFF); put(8'hE0); put(8'h00); put(8'h01);
      send_stream();
      chk("short length err", err, 1'b1);
      put(8'hFF); put(8'hD8); put(8'hFF); put(8'hD4);
      send_stream();
      chk("rst marker outside ecs err", err, 1'b1);
      put(8'hFF); put(8'hD8);
      send_stream();
      chk("err cleared again", err, 1'b0);

      // random frames with random gaps and backpressure
      rnd_ready = 1;
      rnd_gap   = 1;
      for (int f = 0; f < 8; f++) begin
         w = 16'($urandom);
         h = 16'($urandom);
         repeat ($urandom_range(0, 3)) put(8'($urandom_range(0, 254)));
         put(8'hFF); put(8'hD8);
         if ($urandom_range(0, 1) == 1) mk_seg(8'hE0, $urandom_range(0, 6));
         mk_sof(w, h, $urandom_range(0, 5));
         mk_seg(8'hC4, $urandom_range(0, 8));
         mk_seg(8'hDA, $urandom_range(0, 12));
         fs_exp++;
         mk_ecs($urandom_range(0, 11));
         mk_eoi();
         send_stream();
         drain_check($sformatf("rnd%0d", f));
         chk("rnd width", width, w);
         chk("rnd height", height, h);
         chk("rnd err", err, 1'b0);
         chk("rnd overflow", overflow, 1'b0);
      end
      rnd_ready = 0;
      rnd_gap   = 0;
      oready    = 1'b1;

      // reset in the middle of ECS with entries queued
      oready = 1'b0;
      put(8'hFF); put(8'hD8);
      mk_sof(16'h0200, 16'h0100, 0);
      put(8'hFF); put(8'hDA); put(8'h00); put(8'h02);
      fs_exp++;
      for (int i = 0; i < 5; i++) put(8'h21 + 8'(i));
      send_stream();
      chk("mid-reset ovalid before", ovalid, 1'b1);
      chk("mid-reset width before", width, 16'h0200);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("mid-reset ovalid", ovalid, 1'b0);
      chk("mid-reset width", width, 16'h0);
      chk("mid-reset height", height, 16'h0);
      chk("mid-reset oeoi", oeoi, 1'b0);
      oready = 1'b1;
      put(8'h55); put(8'h66);
      mk_min();
      send_stream();
      drain_check("post-reset");
      chk("post-reset width", width, 16'd320);
      chk("post-reset err", err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
